// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter: grants one requester at a time and holds it until its last beat.
// The optional per-requester packet counters are built when ARB_STATS_EN is defined.
module rr_mux_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         grant_sel,
    output logic                     busy,
    output logic [NREQ*16-1:0]       stat_pkts
);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_GRANT = 1'b1;
    localparam logic [SEL_W:0] NREQ_W = (SEL_W+1)'(NREQ);

    logic             state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [SEL_W-1:0] grant_sel_reg, grant_sel_next;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W:0]   best_dist;
    logic [SEL_W:0]   cand_dist;
    logic [SEL_W:0]   cand_w;
    logic [SEL_W:0]   ptr_w;

    logic [NREQ-1:0]   hit;
    logic [NREQ-1:0]   masked_valid;
    logic [NREQ-1:0]   masked_last;
    logic [DATA_W-1:0] masked_data [NREQ];

    logic xfer;
    logic xfer_last;

    assign ptr_w = {1'b0, ptr_reg};

    // Pick the valid requester at the smallest rotational distance from ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        best_dist  = NREQ_W;
        cand_dist  = '0;
        cand_w     = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand_w = (SEL_W+1)'(j);
            if (cand_w >= ptr_w)
                cand_dist = cand_w - ptr_w;
            else
                cand_dist = cand_w + NREQ_W - ptr_w;
            if (req_valid[j] && (cand_dist < best_dist)) begin
                best_dist  = cand_dist;
                pick_idx   = SEL_W'(j);
                pick_found = 1'b1;
            end
        end
    end

    // Lookup-table mux: each entry is keyed by its index and gated by the active grant.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_key
            assign hit[gi]          = (state_reg == STATE_GRANT) && (grant_sel_reg == SEL_W'(gi));
            assign masked_valid[gi] = hit[gi] & req_valid[gi];
            assign masked_last[gi]  = hit[gi] & req_last[gi];
            assign masked_data[gi]  = hit[gi] ? req_data[DATA_W*gi +: DATA_W] : '0;
            assign req_ready[gi]    = hit[gi] & out_ready;
        end
    endgenerate

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            out_data = out_data | masked_data[i];
        end
    end

    assign out_valid = |masked_valid;
    assign out_last  = |masked_last;
    assign xfer      = out_valid & out_ready;
    assign xfer_last = xfer & out_last;
    assign grant_sel = grant_sel_reg;
    assign busy      = (state_reg == STATE_GRANT);

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        grant_sel_next = grant_sel_reg;
        case (state_reg)
            STATE_IDLE: begin
                if (pick_found) begin
                    grant_sel_next = pick_idx;
                    state_next     = STATE_GRANT;
                end
            end
            STATE_GRANT: begin
                if (xfer_last) begin
                    ptr_next   = (grant_sel_reg == SEL_W'(NREQ-1)) ? '0 : grant_sel_reg + 1'b1;
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= STATE_IDLE;
            ptr_reg       <= '0;
            grant_sel_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            grant_sel_reg <= grant_sel_next;
        end
    end

`ifdef ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (masked_valid[gi] && masked_last[gi] && out_ready
                             && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign stat_pkts[16*gi +: 16] = cnt_reg;
        end
    endgenerate
`else
    assign stat_pkts = '0;
`endif

endmodule
